// File: rtl/ram_arbiter.sv
// CPU/DMA arbiter and sequencer in front of the even/odd banked RAM (1-cycle synchronous read).
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed CPU priority.
module ram_arbiter #(
  parameter int unsigned ADDRBITS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_word,
  input  logic [14:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic [15:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic        dma_word,
  input  logic [14:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic        dma_ack,
  output logic        dma_err,
  output logic [15:0] dma_rdata,
  output logic [14:0] read_addr_even,
  output logic [14:0] read_addr_odd,
  output logic [14:0] write_addr_even,
  output logic [14:0] write_addr_odd,
  output logic [7:0]  write_data_even,
  output logic [7:0]  write_data_odd,
  output logic        write_en_even,
  output logic        write_en_odd,
  input  logic [7:0]  read_data_even,
  input  logic [7:0]  read_data_odd
);

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 8;
  localparam logic [15:0] WIN_LO = 16'(32'h4000 - (32'd1 << ADDRBITS));
  localparam logic [15:0] WIN_HI = 16'h3fff;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2} state_t;

  // Window check done in 16 bits so the high byte address of a word cannot wrap.
  function automatic logic in_window(input logic [AW-1:0] a, input logic word);
    logic [15:0] a_lo;
    logic [15:0] a_hi;
    a_lo = 16'(a);
    a_hi = a_lo + 16'(word);
    return (a_lo >= WIN_LO) && (a_hi <= WIN_HI);
  endfunction

  state_t         r_state, w_state_nxt;
  logic           r_port, w_port_nxt;
  logic [AW-1:0]  r_addr, w_addr_nxt;
  logic           r_word, w_word_nxt;
  logic           r_we, w_we_nxt;
  logic           r_err_pend, w_err_pend_nxt;
  logic           r_cpu_ack, w_cpu_ack_nxt, r_cpu_err, w_cpu_err_nxt;
  logic           r_dma_ack, w_dma_ack_nxt, r_dma_err, w_dma_err_nxt;
  logic [AW-1:0]  r_addr_even, w_addr_even_nxt, r_addr_odd, w_addr_odd_nxt;
  logic [BW-1:0]  r_wdata_even, w_wdata_even_nxt, r_wdata_odd, w_wdata_odd_nxt;
  logic           r_wen_even, w_wen_even_nxt, r_wen_odd, w_wen_odd_nxt;

  logic           w_grant_dma, w_any_req, w_sel_we, w_sel_word, w_in_range;
  logic           w_use_even, w_use_odd;
  logic [AW-1:0]  w_sel_addr, w_addr_p1;
  logic [DW-1:0]  w_sel_wdata, w_rdata;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic r_rr_dma;

  // Pointer names the port favoured on the next tie; moves on every fresh grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_rr_dma <= 1'b0;
    else if (r_state == S_IDLE && !r_err_pend && w_any_req)
      r_rr_dma <= !w_grant_dma;
  end
`endif

  always_comb begin : arbitrate
`ifdef RAM_ARB_ROUND_ROBIN_EN
    w_grant_dma = dma_req && (!cpu_req || r_rr_dma);
`else
    w_grant_dma = dma_req && !cpu_req;
`endif
    w_any_req   = cpu_req || dma_req;
    w_sel_addr  = w_grant_dma ? dma_addr  : cpu_addr;
    w_sel_we    = w_grant_dma ? dma_we    : cpu_we;
    w_sel_word  = w_grant_dma ? dma_word  : cpu_word;
    w_sel_wdata = w_grant_dma ? dma_wdata : cpu_wdata;
    w_addr_p1   = w_sel_addr + AW'(1);
    w_in_range  = in_window(w_sel_addr, w_sel_word);
    w_use_even  = w_sel_word || !w_sel_addr[0];
    w_use_odd   = w_sel_word || w_sel_addr[0];
  end

  always_comb begin : next_state
    w_state_nxt      = r_state;
    w_port_nxt       = r_port;
    w_addr_nxt       = r_addr;
    w_word_nxt       = r_word;
    w_we_nxt         = r_we;
    w_err_pend_nxt   = 1'b0;
    w_cpu_ack_nxt    = 1'b0;
    w_cpu_err_nxt    = 1'b0;
    w_dma_ack_nxt    = 1'b0;
    w_dma_err_nxt    = 1'b0;
    w_addr_even_nxt  = r_addr_even;
    w_addr_odd_nxt   = r_addr_odd;
    w_wdata_even_nxt = r_wdata_even;
    w_wdata_odd_nxt  = r_wdata_odd;
    w_wen_even_nxt   = 1'b0;
    w_wen_odd_nxt    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_err_pend) begin
          // Out-of-window grant spent one idle cycle in place of ACCESS.
          w_state_nxt   = S_RESP;
          w_cpu_ack_nxt = !r_port;
          w_cpu_err_nxt = !r_port;
          w_dma_ack_nxt = r_port;
          w_dma_err_nxt = r_port;
        end else if (w_any_req) begin
          w_port_nxt = w_grant_dma;
          w_addr_nxt = w_sel_addr;
          w_word_nxt = w_sel_word;
          w_we_nxt   = w_sel_we;
          if (w_in_range) begin
            w_state_nxt = S_ACCESS;
            if (w_use_even) begin
              w_addr_even_nxt  = w_sel_addr[0] ? w_addr_p1 : w_sel_addr;
              w_wdata_even_nxt = w_sel_addr[0] ? w_sel_wdata[15:8] : w_sel_wdata[7:0];
              w_wen_even_nxt   = w_sel_we;
            end
            if (w_use_odd) begin
              w_addr_odd_nxt  = w_sel_addr[0] ? w_sel_addr : w_addr_p1;
              w_wdata_odd_nxt = w_sel_addr[0] ? w_sel_wdata[7:0] : w_sel_wdata[15:8];
              w_wen_odd_nxt   = w_sel_we;
            end
          end else begin
            w_err_pend_nxt = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        w_state_nxt   = S_RESP;
        w_cpu_ack_nxt = !r_port;
        w_dma_ack_nxt = r_port;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_port       <= 1'b0;
      r_addr       <= '0;
      r_word       <= 1'b0;
      r_we         <= 1'b0;
      r_err_pend   <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_cpu_err    <= 1'b0;
      r_dma_ack    <= 1'b0;
      r_dma_err    <= 1'b0;
      r_addr_even  <= '0;
      r_addr_odd   <= '0;
      r_wdata_even <= '0;
      r_wdata_odd  <= '0;
      r_wen_even   <= 1'b0;
      r_wen_odd    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_port       <= w_port_nxt;
      r_addr       <= w_addr_nxt;
      r_word       <= w_word_nxt;
      r_we         <= w_we_nxt;
      r_err_pend   <= w_err_pend_nxt;
      r_cpu_ack    <= w_cpu_ack_nxt;
      r_cpu_err    <= w_cpu_err_nxt;
      r_dma_ack    <= w_dma_ack_nxt;
      r_dma_err    <= w_dma_err_nxt;
      r_addr_even  <= w_addr_even_nxt;
      r_addr_odd   <= w_addr_odd_nxt;
      r_wdata_even <= w_wdata_even_nxt;
      r_wdata_odd  <= w_wdata_odd_nxt;
      r_wen_even   <= w_wen_even_nxt;
      r_wen_odd    <= w_wen_odd_nxt;
    end
  end

  // Bank read data arrives in RESP; reassemble little-endian from the latched address.
  always_comb begin : read_assemble
    if (r_word)
      w_rdata = r_addr[0] ? {read_data_even, read_data_odd} : {read_data_odd, read_data_even};
    else
      w_rdata = {8'h00, (r_addr[0] ? read_data_odd : read_data_even)};
  end

  assign cpu_ack         = r_cpu_ack;
  assign cpu_err         = r_cpu_err;
  assign dma_ack         = r_dma_ack;
  assign dma_err         = r_dma_err;
  assign cpu_rdata       = (r_cpu_ack && !r_cpu_err && !r_we) ? w_rdata : '0;
  assign dma_rdata       = (r_dma_ack && !r_dma_err && !r_we) ? w_rdata : '0;
  assign read_addr_even  = r_addr_even;
  assign write_addr_even = r_addr_even;
  assign read_addr_odd   = r_addr_odd;
  assign write_addr_odd  = r_addr_odd;
  assign write_data_even = r_wdata_even;
  assign write_data_odd  = r_wdata_odd;
  assign write_en_even   = r_wen_even;
  assign write_en_odd    = r_wen_odd;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Sequencer and two-requester arbiter in front of the banked even/odd RAM, which has a 1-cycle synchronous read. It gives the CPU port and the DMA port byte or little-endian 16-bit access to the RAM window. It splits each access across the even and odd banks, including unaligned words, and rejects out-of-window accesses with an error response. One transaction is in flight at a time, with fixed 2-cycle latency from grant to acknowledge.

## Interface
- ADDRBITS, 10: RAM window is 2^ADDRBITS bytes at 0x4000-2^ADDRBITS .. 0x3fff; each bank has 2^(ADDRBITS-1) entries.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req / dma_req  in  1  request; held until the matching ack.
- cpu_we / dma_we  in  1  1 = write, 0 = read.
- cpu_word / dma_word  in  1  1 = 16-bit access, 0 = byte access.
- cpu_addr / dma_addr  in  15  byte address.
- cpu_wdata / dma_wdata  in  16  write data; a byte write uses [7:0].
- cpu_ack / dma_ack  out  1  one-cycle completion pulse.
- cpu_err / dma_err  out  1  valid with ack; 1 = address outside the window.
- cpu_rdata / dma_rdata  out  16  valid with ack on reads; a byte read returns {8'h00, byte}; 0 on error.
- read_addr_even / read_addr_odd / write_addr_even / write_addr_odd  out  15  bank-side byte addresses.
- write_data_even / write_data_odd  out  8  bank write data.
- write_en_even / write_en_odd  out  1  bank write strobes.
- read_data_even / read_data_odd  in  8  bank read data, valid the cycle after the address.

## Operation
- States:
  - IDLE: arbitrate, latch the winner's addr, we, word, wdata and the granted-port ID.
  - ACCESS: drive the banks.
  - RESP: pulse ack/err to the granted port, assemble rdata.
  - Transitions:
    - IDLE -> ACCESS, or IDLE -> RESP when the latched request is out of range.
    - ACCESS -> RESP.
    - RESP -> IDLE always.
- Range check on latched addr A:
  - In range when A >= 0x4000-2^ADDRBITS.
  - For a word access, A+1 <= 0x3fff is also required, so a word at 0x3fff is an error.
  - Compute the check in 16 bits so A+1 does not wrap.
- Bank mapping, little-endian, bank index = byte address [ADDRBITS-1:1]:
  - Byte at even A: even bank at A.
  - Byte at odd A: odd bank at A.
  - Word at even A: low byte in even bank at A, high byte in odd bank at A+1 (same index).
  - Word at odd A: low byte in odd bank at A, high byte in even bank at A+1 (index +1). This is still a single cycle, because the two bytes are in different banks.
- Read and write addresses to a bank are driven with the same value.
- Banks not used by the access: write_en = 0, addresses held at their previous value.
- Writes: write_en is asserted only during ACCESS, only for the banks touched; data is routed per the mapping.
- Reads in RESP: rdata is assembled combinationally from read_data_even/odd per the latched mapping.
- Errors: no bank is ever written; err = 1 and rdata = 0 with the ack.
- Requests arriving while not in IDLE wait. The losing requester stays pending and is served in the next IDLE.
- The requester holds req and its fields until ack and may drop req in the ack cycle. Deasserting req before ack is not supported; the latched transaction still completes.
- A requester with req still high in the cycle after ack is treated as a new request.

## Timing
- Reset values:
  - State IDLE.
  - All ack, err and write_en outputs 0.
  - rdata 0.
  - Bank addresses and write data 0.
  - Round-robin pointer favours CPU.
- Latency:
  - req seen in IDLE at cycle T.
  - Banks driven at T+1.
  - ack at T+2; an error ack also comes at T+2, with T+1 spent idle in place of ACCESS.
  - Peak throughput: one transaction per 3 cycles.
- Reset asserted mid-transaction:
  - Immediate return to reset values; no ack is issued.
  - A write already strobed in ACCESS may have occurred.

## Configuration
- RAM_ARB_ROUND_ROBIN_EN defined:
  - When both requesters are in IDLE together, the grant goes to the port not granted last.
  - The pointer updates on every grant, including error grants.
- Undefined: fixed priority, CPU always wins; DMA can starve, which is accepted.

## Test plan
- ADDRBITS=10: CPU word write 0xBEEF at 0x3c00, then word read 0x3c00 -> rdata 0xBEEF with ack at T+2; write_en_even and write_en_odd both pulse in the same cycle.
- CPU word write 0x1234 at 0x3c05 -> odd bank index 2 gets 0x34, even bank index 3 gets 0x12; byte read 0x3c06 -> 0x0012.
- Word read at 0x3fff, and byte write at 0x3bff -> err=1, rdata=0, ack at T+2, no write_en ever asserted.
- CPU and DMA requesting simultaneously and continuously:
  - With RAM_ARB_ROUND_ROBIN_EN: grants alternate CPU, DMA, CPU.
  - Without it: CPU gets every grant while it keeps requesting.
- Reset asserted during ACCESS of a read -> ack never pulses, outputs return to 0; a request issued after reset completes normally with the correct data.
